// File: rtl/r_backward_fifo.sv
// Elastic FIFO for packed AXI4 R flits on the return path: registered IN_READY/OUT_VALID,
// first-word fall-through head, plus a count of buffered RLAST flits for whole-burst arbitration.
module r_backward_fifo #(
    parameter int WIDTH = 79,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [AW:0]      COUNT,
    output logic [AW:0]      BURSTS
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   bursts_q, bursts_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;

    logic push, pop, push_last, pop_last;
    logic [WIDTH-1:0] head;

    // Handshakes use only registered flags, so OUT_READY never reaches IN_READY combinationally.
    assign head      = mem_q[rd_ptr_q];
    assign push      = IN_VALID & in_ready_q;
    assign pop       = out_valid_q & OUT_READY;
    assign push_last = push & IN_DATA[0];
    assign pop_last  = pop & head[0];

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        bursts_d    = bursts_q + (AW+1)'(push_last) - (AW+1)'(pop_last);
        out_valid_d = (count_d != '0);
        in_ready_d  = (count_d != FULL_COUNT);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            bursts_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            bursts_q    <= bursts_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Storage is not reset; stale entries are unreachable because pointers and flags are.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= IN_DATA;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = head;
    assign COUNT     = count_q;
    assign BURSTS    = bursts_q;

endmodule

// File: tb/tb_r_backward_fifo.sv
// Bench for r_backward_fifo: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based model of the FIFO contents.
module tb_r_backward_fifo;

    localparam int WIDTH = 79;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             ACLK = 1'b0;
    logic             ARESETn = 1'b0;
    logic [WIDTH-1:0] IN_DATA = '0;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic [AW:0]      COUNT;
    logic [AW:0]      BURSTS;

    int n_total = 0;
    int n_pass  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             rdy_model = 1'b0;

    r_backward_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .OUT_DATA (OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .COUNT    (COUNT),
        .BURSTS   (BURSTS)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [7:0] rid, input logic [63:0] data,
                                             input logic [1:0] resp, input logic [3:0] user,
                                             input logic last);
        return {rid, data, resp, user, last};
    endfunction

    function automatic logic [WIDTH-1:0] rnd_flit();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    // IN_READY becomes 1 on the first clock edge seen with reset released.
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rdy_model <= 1'b0;
        else          rdy_model <= 1'b1;
    end

    always @(negedge ARESETn) exp_q.delete();

    // Monitor: compare flags/counters with the model, pop on observed handshake, record accepted pushes.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            check("rst_out_valid", WIDTH'(OUT_VALID), '0);
            check("rst_in_ready",  WIDTH'(IN_READY), '0);
            check("rst_count",     WIDTH'(COUNT), '0);
        end else begin
            automatic int nl = 0;
            foreach (exp_q[i]) if (exp_q[i][0]) nl++;
            check("mon_out_valid", WIDTH'(OUT_VALID), WIDTH'(exp_q.size() != 0));
            check("mon_in_ready",  WIDTH'(IN_READY), WIDTH'(rdy_model && exp_q.size() != DEPTH));
            check("mon_count",     WIDTH'(COUNT), WIDTH'(exp_q.size()));
            check("mon_bursts",    WIDTH'(BURSTS), WIDTH'(nl));
            if (OUT_VALID && OUT_READY && exp_q.size() != 0) begin
                check("mon_data", OUT_DATA, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (IN_VALID && IN_READY) exp_q.push_back(IN_DATA);
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drain();
        int guard;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        guard = 0;
        while (COUNT != 0 && guard < 64) begin
            tick();
            guard++;
        end
        check("drain_done", WIDTH'(COUNT), '0);
        OUT_READY = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] f;
        int idx, pushed, cyc;
        logic acc;

        // Reset held 3 cycles, released between edges.
        repeat (3) tick();
        check("rst_hold_in_ready", WIDTH'(IN_READY), '0);
        ARESETn = 1'b1;
        #1;
        check("rel_in_ready_before_edge", WIDTH'(IN_READY), '0);
        tick();
        check("rel_in_ready_after_edge", WIDTH'(IN_READY), 1);
        check("rel_out_valid", WIDTH'(OUT_VALID), '0);
        check("rel_count", WIDTH'(COUNT), '0);
        check("rel_bursts", WIDTH'(BURSTS), '0);
        $display("txn reset: done");

        // Single flit, held 4 cycles, then popped.
        f = mk(8'h5A, 64'hDEADBEEF_00000001, 2'b00, 4'h3, 1'b1);
        IN_DATA = f; IN_VALID = 1'b1; OUT_READY = 1'b0;
        tick();
        IN_VALID = 1'b0;
        check("single_out_valid", WIDTH'(OUT_VALID), 1);
        check("single_data", OUT_DATA, f);
        check("single_count", WIDTH'(COUNT), 1);
        check("single_bursts", WIDTH'(BURSTS), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_hold_data", OUT_DATA, f);
            check("single_hold_valid", WIDTH'(OUT_VALID), 1);
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("single_pop_count", WIDTH'(COUNT), '0);
        check("single_pop_bursts", WIDTH'(BURSTS), '0);
        $display("txn single flit: data=%h", f);

        // Fill: 10 attempts, 8 accepted.
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            IN_DATA  = mk(8'h00, 64'(idx), 2'b00, 4'h0, (idx % 4) == 3);
            IN_VALID = 1'b1;
            acc = IN_READY;
            tick();
            if (acc) idx++;
        end
        check("fill_accepted", WIDTH'(idx), 8);
        check("fill_in_ready", WIDTH'(IN_READY), '0);
        check("fill_count", WIDTH'(COUNT), 8);
        check("fill_bursts", WIDTH'(BURSTS), 2);
        $display("txn fill: accepted=%0d count=%0d bursts=%0d", idx, COUNT, BURSTS);

        // Full + pop: no push this cycle, slot reopens next cycle.
        IN_DATA = mk(8'h00, 64'(idx), 2'b00, 4'h0, 1'b0);
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("fullpop_count", WIDTH'(COUNT), 7);
        check("fullpop_in_ready", WIDTH'(IN_READY), 1);
        tick();
        IN_VALID = 1'b0;
        check("fullpop_refill_count", WIDTH'(COUNT), 8);
        drain();
        $display("txn full+pop and drain: count=%0d", COUNT);

        // Streaming: continuous valid/ready, occupancy stays at one.
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int i = 0; i < 40; i++) begin
            IN_DATA = rnd_flit();
            tick();
            check("stream_count", WIDTH'(COUNT), 1);
        end
        drain();
        $display("txn streaming: 40 flits");

        // Random traffic.
        pushed = 0; cyc = 0;
        while (pushed < 2000 && cyc < 20000) begin
            IN_DATA   = rnd_flit();
            IN_VALID  = 1'($urandom_range(0, 1));
            OUT_READY = 1'($urandom_range(0, 1));
            acc = IN_VALID & IN_READY;
            tick();
            if (acc) pushed++;
            cyc++;
        end
        check("random_pushed", WIDTH'(pushed), 2000);
        drain();
        $display("txn random: pushed=%0d cycles=%0d", pushed, cyc);

        // Mid-burst reset.
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            IN_DATA  = mk(8'h11, 64'(100 + i), 2'b00, 4'h0, i == 2);
            IN_VALID = 1'b1;
            tick();
        end
        IN_VALID = 1'b0;
        check("mid_count", WIDTH'(COUNT), 5);
        check("mid_bursts", WIDTH'(BURSTS), 1);
        @(posedge ACLK);
        #3;
        ARESETn = 1'b0;
        #1;
        check("mid_rst_out_valid", WIDTH'(OUT_VALID), '0);
        check("mid_rst_in_ready", WIDTH'(IN_READY), '0);
        check("mid_rst_count", WIDTH'(COUNT), '0);
        check("mid_rst_bursts", WIDTH'(BURSTS), '0);
        ARESETn = 1'b1;
        tick();
        f = mk(8'hA5, 64'h0123_4567_89AB_CDEF, 2'b01, 4'h9, 1'b1);
        IN_DATA = f; IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        check("post_rst_first_data", OUT_DATA, f);
        check("post_rst_count", WIDTH'(COUNT), 1);
        drain();
        $display("txn mid-burst reset: first=%h", f);

        repeat (2) tick();
        check("final_model_empty", WIDTH'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
